memory_controller: RTL and testbench

- Single-port arbiter between instruction fetch and the load/store buffer (LSB) on one side, and the byte-wide unified RAM/IO bus on the other.
- Serialises each 1/2/4-byte access into per-byte RAM cycles, assembles and sign/zero-extends load data, and returns one-cycle ready pulses.
- Sits directly downstream of the LSB's mc_* port and the fetch unit's if_* port.

---
 rtl/mem_defs.sv | 37 +++
 rtl/load_extend.sv | 27 ++
 rtl/memory_controller.sv | 188 ++++++++++++++++++
 tb/tb_memory_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
`default_nettype none
// ============================================================================
//  Module      : mem_defs (package)
//  Description : Shared access-type encoding, IO window base and controller
//                state encoding for the byte-serial memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_defs;

    localparam int MC_STORE    = 3;
    localparam int MC_UNSIGNED = 2;

    localparam logic [1:0] MC_BYTE = 2'b00;
    localparam logic [1:0] MC_HALF = 2'b01;
    localparam logic [1:0] MC_WORD = 2'b10;

    localparam logic [3:0]  MC_TYPE_FETCH   = {2'b00, MC_WORD};
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } mc_state_e;

    // Width code 11 is illegal and is serviced as a full word.
    function automatic logic [2:0] mc_nbytes(input logic [3:0] mc_type);
        case (mc_type[1:0])
            MC_BYTE: return 3'd1;
            MC_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Sign/zero-extends assembled load data by access width.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_defs::*;
(
    input  logic [31:0] raw_i,
    input  logic [3:0]  type_i,
    output logic [31:0] result_o
);

    logic sext;

    always_comb begin
        sext = ~type_i[MC_UNSIGNED];
        case (type_i[1:0])
            MC_BYTE: result_o = {{24{sext & raw_i[7]}},  raw_i[7:0]};
            MC_HALF: result_o = {{16{sext & raw_i[15]}}, raw_i[15:0]};
            default: result_o = raw_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
//  Module      : memory_controller
//  Description : Arbitrates fetch and LSB requests onto a byte-wide RAM/IO
//                bus, serialising multi-byte accesses one byte per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_controller
    import mem_defs::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
)
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic        mc_en,
    input  logic [31:0] mc_addr,
    input  logic [3:0]  mc_type,
    input  logic [31:0] mc_write_data,
    output logic        mc_rdy,
    output logic [31:0] mc_read_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mc_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  type_q, type_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fetch_q, fetch_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] raw_q, raw_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mc_data_q, mc_data_d;
    logic [31:0] mem_a_q;
    logic [7:0]  dout_q;

    logic [2:0]  nbytes;
    logic [2:0]  idx;
    logic [31:0] cur_a;
    logic [7:0]  cur_byte;
    logic        io_stall;
    logic        busy;
    logic [31:0] ext_data;

    load_extend u_load_extend (
        .raw_i    (raw_d),
        .type_i   (type_q),
        .result_o (ext_data)
    );

    // In the final READ cycle only a capture happens; keep the last address on the bus.
    always_comb begin
        nbytes = mc_nbytes(type_q);
        busy   = (state_q == S_READ) || (state_q == S_WRITE);
        if ((state_q == S_READ) && (cnt_q == nbytes)) begin
            idx = nbytes - 3'd1;
        end else begin
            idx = cnt_q;
        end
        cur_a = addr_q + {29'd0, idx};
        case (idx[1:0])
            2'd0:    cur_byte = wdata_q[7:0];
            2'd1:    cur_byte = wdata_q[15:8];
            2'd2:    cur_byte = wdata_q[23:16];
            default: cur_byte = wdata_q[31:24];
        endcase
        io_stall = io_buffer_full && (cur_a >= IO_BASE);
    end

    assign mem_a        = busy ? cur_a : mem_a_q;
    assign mem_dout     = (state_q == S_WRITE) ? cur_byte : dout_q;
    assign mem_wr       = rdy_in && (state_q == S_WRITE) && !io_stall;
    assign if_data      = if_data_q;
    assign mc_read_data = mc_data_q;
    assign if_rdy       = rdy_in && (state_q == S_DONE) && fetch_q && !flush;
    assign mc_rdy       = rdy_in && (state_q == S_DONE) && !fetch_q
                          && !(flush && !type_q[MC_STORE]);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        type_d    = type_q;
        wdata_d   = wdata_q;
        fetch_d   = fetch_q;
        cnt_d     = cnt_q;
        raw_d     = raw_q;
        if_data_d = if_data_q;
        mc_data_d = mc_data_q;

        if (state_q == S_READ) begin
            case (cnt_q)
                3'd1:    raw_d[7:0]   = mem_din;
                3'd2:    raw_d[15:8]  = mem_din;
                3'd3:    raw_d[23:16] = mem_din;
                3'd4:    raw_d[31:24] = mem_din;
                default: raw_d        = raw_q;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                // Stores are committed, so a flush cannot refuse them.
                if (mc_en && (!flush || mc_type[MC_STORE])) begin
                    addr_d  = mc_addr;
                    type_d  = mc_type;
                    wdata_d = mc_write_data;
                    fetch_d = 1'b0;
                    cnt_d   = 3'd0;
                    raw_d   = 32'd0;
                    state_d = mc_type[MC_STORE] ? S_WRITE : S_READ;
                end else if (if_en && !flush) begin
                    addr_d  = if_addr;
                    type_d  = MC_TYPE_FETCH;
                    fetch_d = 1'b1;
                    cnt_d   = 3'd0;
                    raw_d   = 32'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == nbytes) begin
                    state_d = S_DONE;
                    if (fetch_q) begin
                        if_data_d = raw_d;
                    end else begin
                        mc_data_d = ext_data;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WRITE: begin
                if (!io_stall) begin
                    if (cnt_q == nbytes - 3'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            type_q    <= 4'd0;
            wdata_q   <= 32'd0;
            fetch_q   <= 1'b0;
            cnt_q     <= 3'd0;
            raw_q     <= 32'd0;
            if_data_q <= 32'd0;
            mc_data_q <= 32'd0;
            mem_a_q   <= 32'd0;
            dout_q    <= 8'd0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            wdata_q   <= wdata_d;
            fetch_q   <= fetch_d;
            cnt_q     <= cnt_d;
            raw_q     <= raw_d;
            if_data_q <= if_data_d;
            mc_data_q <= mc_data_d;
            mem_a_q   <= mem_a;
            dout_q    <= mem_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_controller
//  Description : Directed self-checking bench with a byte-wide RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_controller;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        if_en, if_rdy, mc_en, mc_rdy, mem_wr, io_buffer_full;
    logic [31:0] if_addr, if_data, mc_addr, mc_write_data, mc_read_data, mem_a;
    logic [3:0]  mc_type;
    logic [7:0]  mem_din, mem_dout;

    int errors = 0;
    int checks = 0;
    int io_writes = 0;
    logic [7:0] io_last = 8'h00;
    logic [7:0] ram [0:4095];

    memory_controller dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush          (flush),
        .if_en          (if_en),
        .if_addr        (if_addr),
        .if_rdy         (if_rdy),
        .if_data        (if_data),
        .mc_en          (mc_en),
        .mc_addr        (mc_addr),
        .mc_type        (mc_type),
        .mc_write_data  (mc_write_data),
        .mc_rdy         (mc_rdy),
        .mc_read_data   (mc_read_data),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            if (mem_a >= 32'h0003_0000) begin
                io_writes = io_writes + 1;
                io_last   = mem_dout;
            end else begin
                ram[mem_a[11:0]] = mem_dout;
            end
        end
    end

    task automatic test_reset();
        #1;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        checks++; if ({if_rdy, mc_rdy} !== 2'b00) begin errors++; $display("FAIL reset_rdy: got %b want 00", {if_rdy, mc_rdy}); end
        checks++; if ({if_data, mc_read_data} !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {if_data, mc_read_data}); end
        @(negedge clk_in); @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_fetch();
        @(negedge clk_in); if_en = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in); #1;
            if (c <= 4) begin
                checks++; if (mem_a !== 32'h100 + 32'(c) - 32'd1) begin errors++; $display("FAIL fetch_addr c%0d: got %h want %h", c, mem_a, 32'h100 + 32'(c) - 32'd1); end
            end
            checks++; if (if_rdy !== (c == 6)) begin errors++; $display("FAIL fetch_rdy c%0d: got %b want %b", c, if_rdy, (c == 6)); end
            if (c == 6) begin
                checks++; if (if_data !== 32'h0010_0513) begin errors++; $display("FAIL fetch_data: got %h want 00100513", if_data); end
                if_en = 1'b0;
            end
        end
        checks++; if (mem_a !== 32'h103) begin errors++; $display("FAIL fetch_hold_addr: got %h want 103", mem_a); end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [6] = '{32'h204, 32'h204, 32'h208, 32'h208, 32'h20C, 32'h100};
        logic [3:0]  types [6] = '{4'b0000, 4'b0100, 4'b0101, 4'b0001, 4'b0011, 4'b0110};
        logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_FF80,
                                   32'hFFFF_FF80, 32'h8433_2211, 32'h0010_0513};
        int          lats  [6] = '{3, 3, 4, 4, 6, 6};
        for (int v = 0; v < 6; v++) begin
            int lat = 0;
            @(negedge clk_in); mc_en = 1'b1; mc_addr = addrs[v]; mc_type = types[v];
            for (int c = 1; c <= 12 && lat == 0; c++) begin
                @(negedge clk_in); #1;
                if (mc_rdy) lat = c;
            end
            mc_en = 1'b0;
            checks++; if (lat !== lats[v]) begin errors++; $display("FAIL load_latency v%0d: got %0d want %0d", v, lat, lats[v]); end
            checks++; if (mc_read_data !== exps[v]) begin errors++; $display("FAIL load_data v%0d: got %h want %h", v, mc_read_data, exps[v]); end
        end
        @(negedge clk_in);
    endtask

    task automatic test_store_word();
        logic [7:0] bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h40; mc_type = 4'b1010; mc_write_data = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in); #1;
            if (c <= 4) begin
                checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h40 + 32'(c) - 32'd1, bytes[c-1]}) begin
                    errors++; $display("FAIL store_bus c%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h", c, mem_wr, mem_a, mem_dout, 32'h40 + 32'(c) - 32'd1, bytes[c-1]);
                end
            end
            checks++; if (mc_rdy !== (c == 5)) begin errors++; $display("FAIL store_rdy c%0d: got %b want %b", c, mc_rdy, (c == 5)); end
        end
        mc_en = 1'b0;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL store_wr_done: got %b want 0", mem_wr); end
        @(negedge clk_in);
        checks++; if ({ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]} !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_ram: got %h want deadbeef", {ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]});
        end
    endtask

    task automatic test_io_stall();
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h0003_0000; mc_type = 4'b1000; mc_write_data = 32'h0000_005A;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in); io_buffer_full = (c <= 3); #1;
            if (c <= 4) begin
                checks++; if (mem_wr !== (c == 4)) begin errors++; $display("FAIL io_wr c%0d: got %b want %b", c, mem_wr, (c == 4)); end
            end
            checks++; if (mc_rdy !== (c == 5)) begin errors++; $display("FAIL io_rdy c%0d: got %b want %b", c, mc_rdy, (c == 5)); end
            if (c == 5) mc_en = 1'b0;
        end
        checks++; if ({io_writes, io_last} !== {32'd1, 8'h5A}) begin errors++; $display("FAIL io_count: got %0d/%h want 1/5a", io_writes, io_last); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h204; mc_type = 4'b0000; if_en = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk_in); #1;
            checks++; if ({mc_rdy, if_rdy} !== {c == 3, c == 10}) begin
                errors++; $display("FAIL b2b_rdy c%0d: got mc=%b if=%b want mc=%b if=%b", c, mc_rdy, if_rdy, (c == 3), (c == 10));
            end
            if (c == 1) begin
                checks++; if (mem_a !== 32'h204) begin errors++; $display("FAIL b2b_lsb_first: got %h want 204", mem_a); end
            end
            if (c == 3) begin
                checks++; if (mc_read_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL b2b_load_data: got %h want ffffff80", mc_read_data); end
                mc_en = 1'b0;
            end
            if (c == 5) begin
                checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL b2b_fetch_addr: got %h want 100", mem_a); end
            end
            if (c == 10) if_en = 1'b0;
        end
        checks++; if (mem_a !== 32'h103) begin errors++; $display("FAIL b2b_no_reissue: got %h want 103", mem_a); end
    endtask

    task automatic test_rdy_hold();
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h204; mc_type = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in); rdy_in = !(c <= 2); #1;
            checks++; if (mc_rdy !== (c == 5)) begin errors++; $display("FAIL rdy_hold c%0d: got %b want %b", c, mc_rdy, (c == 5)); end
            if (c == 5) mc_en = 1'b0;
        end
        checks++; if (mc_read_data !== 32'h0000_0080) begin errors++; $display("FAIL rdy_hold_data: got %h want 00000080", mc_read_data); end
    endtask

    task automatic test_flush();
        // Flush during READ of a word load.
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h100; mc_type = 4'b0010;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_in);
            if (c == 2) begin flush = 1'b1; mc_en = 1'b0; end
            if (c == 3) flush = 1'b0;
            #1;
            checks++; if (mc_rdy !== 1'b0) begin errors++; $display("FAIL flush_read_rdy c%0d: got %b want 0", c, mc_rdy); end
            if (c == 4) begin
                checks++; if (mem_a !== 32'h101) begin errors++; $display("FAIL flush_read_idle: got %h want 101", mem_a); end
            end
        end
        // Flush in the DONE cycle of a byte load.
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h204; mc_type = 4'b0000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in);
            if (c == 3) flush = 1'b1;
            #1;
            checks++; if (mc_rdy !== 1'b0) begin errors++; $display("FAIL flush_done_rdy c%0d: got %b want 0", c, mc_rdy); end
            if (c == 3) begin flush = 1'b0; mc_en = 1'b0; end
        end
        // Flush coinciding with a load request in IDLE.
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h100; mc_type = 4'b0010; flush = 1'b1;
        @(negedge clk_in); mc_en = 1'b0; flush = 1'b0; #1;
        checks++; if (mem_a !== 32'h204) begin errors++; $display("FAIL flush_idle_accept: got %h want 204", mem_a); end
        // Flush throughout a word store.
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h50; mc_type = 4'b1010; mc_write_data = 32'h1234_5678; flush = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in); #1;
            checks++; if ({mem_wr, mc_rdy} !== {c <= 4, c == 5}) begin
                errors++; $display("FAIL flush_store c%0d: got wr=%b rdy=%b want wr=%b rdy=%b", c, mem_wr, mc_rdy, (c <= 4), (c == 5));
            end
        end
        mc_en = 1'b0; flush = 1'b0;
        @(negedge clk_in);
        checks++; if ({ram[12'h53], ram[12'h52], ram[12'h51], ram[12'h50]} !== 32'h1234_5678) begin
            errors++; $display("FAIL flush_store_ram: got %h want 12345678", {ram[12'h53], ram[12'h52], ram[12'h51], ram[12'h50]});
        end
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk_in); mc_en = 1'b1; mc_addr = 32'h60; mc_type = 4'b1010; mc_write_data = 32'hCAFE_F00D;
        @(negedge clk_in); @(negedge clk_in); #1;
        checks++; if ({mem_wr, mem_a} !== {1'b1, 32'h61}) begin errors++; $display("FAIL rst_pre: got wr=%b a=%h want wr=1 a=61", mem_wr, mem_a); end
        rst_in = 1'b0; mc_en = 1'b0; #1;
        checks++; if ({mem_wr, mem_a, mem_dout, if_rdy, mc_rdy} !== 43'd0) begin
            errors++; $display("FAIL rst_mid_bus: got wr=%b a=%h d=%h rdy=%b%b want all 0", mem_wr, mem_a, mem_dout, if_rdy, mc_rdy);
        end
        checks++; if ({if_data, mc_read_data} !== 64'd0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", {if_data, mc_read_data}); end
        @(negedge clk_in); rst_in = 1'b1;
        @(negedge clk_in); @(negedge clk_in); #1;
        checks++; if ({mem_wr, ram[12'h62], ram[12'h60]} !== {1'b0, 8'h00, 8'h0D}) begin
            errors++; $display("FAIL rst_abandon: got wr=%b b2=%h b0=%h want 0/00/0d", mem_wr, ram[12'h62], ram[12'h60]);
        end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; if_en = 1'b0; if_addr = 32'd0;
        mc_en = 1'b0; mc_addr = 32'd0; mc_type = 4'd0; mc_write_data = 32'd0; io_buffer_full = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]} = 32'h0010_0513;
        ram[12'h204] = 8'h80;
        {ram[12'h209], ram[12'h208]} = 16'hFF80;
        {ram[12'h20F], ram[12'h20E], ram[12'h20D], ram[12'h20C]} = 32'h8433_2211;
        test_reset();
        test_fetch();
        test_loads();
        test_store_word();
        test_io_stall();
        test_back_to_back();
        test_rdy_hold();
        test_flush();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
